icache_line_adapter: RTL and testbench

ICACHE_LINE_ADAPTER -- requirements
Module: icache_line_adapter

---
 rtl/cache_types_pkg.sv | 23 ++
 rtl/icache_line_adapter_perf.sv | 25 ++
 rtl/icache_line_adapter.sv | 115 +++++++++++
 tb/tb_icache_line_adapter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Shared cache types: adapter FSM state encoding and line/beat geometry helpers.
package cache_types_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } adapter_state_t;

    function automatic int line_beats(input int line_bits, input int burst_bits);
        return line_bits / burst_bits;
    endfunction

    // Keep a one-bit counter even for single-beat lines so the slice index stays legal.
    function automatic int beat_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic logic [31:0] line_align(input logic [31:0] addr, input int offset_bits);
        return addr & ~((32'd1 << offset_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_line_adapter_perf.sv
// Saturating performance counters for the icache line adapter (ICACHE_ADAPTER_PERF_EN builds only).
module icache_line_adapter_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_burst,
    input  logic        line_done,
    output logic [31:0] perf_lines,
    output logic [31:0] perf_stall
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lines <= '0;
            perf_stall <= '0;
        end else begin
            if (line_done && (perf_lines != 32'hFFFF_FFFF)) begin
                perf_lines <= perf_lines + 32'd1;
            end
            if (in_burst && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end

endmodule

// File: rtl/icache_line_adapter.sv
// Assembles one cache line from a burst of memory beats; ICACHE_ADAPTER_PERF_EN adds perf counter ports.
module icache_line_adapter
    import cache_types_pkg::*;
#(
    parameter int s_offset = 5,
    parameter int s_line   = 8 * 2**s_offset,
    parameter int s_burst  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pmem_read,
    input  logic [31:0]         pmem_address,
    output logic [s_line-1:0]   pmem_rdata,
    output logic                pmem_resp,
    output logic                burst_read,
    output logic [31:0]         burst_address,
    input  logic [s_burst-1:0]  burst_rdata,
    input  logic                burst_resp
`ifdef ICACHE_ADAPTER_PERF_EN
    ,
    output logic [31:0]         perf_lines,
    output logic [31:0]         perf_stall
`endif
);

    localparam int BEATS = line_beats(s_line, s_burst);
    localparam int CNT_W = beat_cnt_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    adapter_state_t       state_q;
    adapter_state_t       state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [31:0]          addr_q;
    logic [s_line-1:0]    line_q;
    logic [s_line-1:0]    full_line;
    logic                 abort_q;
    logic                 last_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_beat = burst_resp && (cnt_q == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pmem_read) state_d = BURST;
            BURST:   if (last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final beat is merged on the fly so the finished line lands in pmem_rdata one edge early.
    always_comb begin
        full_line = line_q;
        full_line[(BEATS-1)*s_burst +: s_burst] = burst_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            line_q     <= '0;
            abort_q    <= 1'b0;
            pmem_rdata <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pmem_read) begin
                        addr_q  <= line_align(pmem_address, s_offset);
                        cnt_q   <= '0;
                        abort_q <= 1'b0;
                    end
                end
                BURST: begin
                    // A dropped request still drains the memory burst, but the line is never published.
                    if (!pmem_read) begin
                        abort_q <= 1'b1;
                    end
                    if (burst_resp) begin
                        line_q[int'(cnt_q)*s_burst +: s_burst] <= burst_rdata;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_beat && pmem_read && !abort_q) begin
                            pmem_rdata <= full_line;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign burst_read    = (state_q == BURST);
    assign burst_address = addr_q;
    assign pmem_resp     = (state_q == DONE) && !abort_q;

`ifdef ICACHE_ADAPTER_PERF_EN
    icache_line_adapter_perf u_perf (
        .clk        (clk),
        .rst        (rst),
        .in_burst   (burst_read),
        .line_done  (pmem_resp),
        .perf_lines (perf_lines),
        .perf_stall (perf_stall)
    );
`endif

endmodule

// File: tb/tb_icache_line_adapter.sv
// Self-checking bench for icache_line_adapter: table vectors, corner sequences and random transactions.
module tb_icache_line_adapter;

    logic          clk = 1'b0;
    logic          rst;
    logic          pmem_read;
    logic [31:0]   pmem_address;
    logic [255:0]  pmem_rdata;
    logic          pmem_resp;
    logic          burst_read;
    logic [31:0]   burst_address;
    logic [63:0]   burst_rdata;
    logic          burst_resp;
`ifdef ICACHE_ADAPTER_PERF_EN
    logic [31:0]   perf_lines;
    logic [31:0]   perf_stall;
`endif

    int errors = 0;
    int checks = 0;
    int model_lines = 0;
    int model_stall = 0;
    logic [255:0] last_line = '0;

    typedef struct {
        logic [31:0] addr;
        int          gap;
        int          abort_after;
        bit          fixed;
        logic [31:0] exp_baddr;
        int          exp_done_n;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    icache_line_adapter #(
        .s_offset (5),
        .s_line   (256),
        .s_burst  (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_read     (pmem_read),
        .pmem_address  (pmem_address),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_read    (burst_read),
        .burst_address (burst_address),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
`ifdef ICACHE_ADAPTER_PERF_EN
        ,
        .perf_lines    (perf_lines),
        .perf_stall    (perf_stall)
`endif
    );

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One line request served by a memory with 'gap' idle cycles between beats.
    task automatic applyStimulus(input logic [31:0] addr, input int gap, input int abort_after,
                                 input bit fixed, input logic [31:0] exp_baddr, input int exp_done_n,
                                 input bit preheld, input bit keep_next, input logic [31:0] next_addr,
                                 input string tag);
        logic [63:0]  beats [4];
        logic [255:0] exp_line;
        int sent;
        int gap_ctr;
        int n;
        int last_n;
        bit br_ok;
        bit addr_ok;
        bit hold_ok;
        bit early_resp;
        bit aborted;

        exp_line = '0;
        for (int k = 0; k < 4; k++) begin
            beats[k] = fixed ? {8{8'(8'h11 * (k + 1))}} : {$urandom, $urandom};
            exp_line[k*64 +: 64] = beats[k];
        end

        pmem_read    = 1'b1;
        pmem_address = addr;
        if (preheld) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, " no accept in DONE"}, 256'(burst_read), 256'(0));
        end
        @(posedge clk);

        sent = 0; gap_ctr = 0; last_n = -1;
        br_ok = 1'b1; addr_ok = 1'b1; hold_ok = 1'b1; early_resp = 1'b0; aborted = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (last_n >= 0 && n == last_n + 1) break;
            if (pmem_resp) early_resp = 1'b1;
            if (!burst_read) br_ok = 1'b0;
            if (burst_address !== exp_baddr) addr_ok = 1'b0;
            if (pmem_rdata !== last_line) hold_ok = 1'b0;
            if (sent < 4 && gap_ctr == 0) begin
                burst_resp  = 1'b1;
                burst_rdata = beats[sent];
                sent++;
                gap_ctr = gap;
                if (sent == 4) last_n = n;
            end else begin
                burst_resp  = 1'b0;
                burst_rdata = {$urandom, $urandom};
                if (gap_ctr > 0) gap_ctr--;
            end
            if (abort_after > 0 && sent >= abort_after) begin
                pmem_read = 1'b0;
                aborted   = 1'b1;
            end
            pmem_address = $urandom;
        end
        burst_resp = 1'b0;

        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: no DONE within 200 cycles", tag);
            pmem_read = 1'b0;
            return;
        end

        checkOutput({tag, " done cycle"}, 256'(n), 256'(exp_done_n));
        checkOutput({tag, " burst_read low in DONE"}, 256'(burst_read), 256'(0));
        checkOutput({tag, " burst_read steady"}, 256'(br_ok), 256'(1));
        checkOutput({tag, " burst_address"}, 256'(addr_ok), 256'(1));
        checkOutput({tag, " rdata held during burst"}, 256'(hold_ok), 256'(1));
        checkOutput({tag, " no early resp"}, 256'(early_resp), 256'(0));
        if (aborted) begin
            checkOutput({tag, " resp suppressed"}, 256'(pmem_resp), 256'(0));
            checkOutput({tag, " rdata kept"}, pmem_rdata, last_line);
        end else begin
            checkOutput({tag, " resp"}, 256'(pmem_resp), 256'(1));
            checkOutput({tag, " line"}, pmem_rdata, exp_line);
            last_line = exp_line;
            model_lines++;
        end
        model_stall += last_n + 1;

        if (keep_next) begin
            pmem_read    = 1'b1;
            pmem_address = next_addr;
        end else begin
            pmem_read = 1'b0;
            @(negedge clk);
            checkOutput({tag, " single resp pulse"}, 256'(pmem_resp), 256'(0));
            checkOutput({tag, " idle after DONE"}, 256'(burst_read), 256'(0));
        end
    endtask

    initial begin
        logic [31:0] raddr;
        int          rgap;
        int          rabort;
        bit          stray_ok;

        vecs[0] = '{addr: 32'h0000_1234, gap: 0, abort_after: 0, fixed: 1'b1, exp_baddr: 32'h0000_1220, exp_done_n: 4};
        vecs[1] = '{addr: 32'h0000_ABCD, gap: 2, abort_after: 0, fixed: 1'b0, exp_baddr: 32'h0000_ABC0, exp_done_n: 10};
        vecs[2] = '{addr: 32'hFFFF_FFFF, gap: 1, abort_after: 0, fixed: 1'b0, exp_baddr: 32'hFFFF_FFE0, exp_done_n: 7};
        vecs[3] = '{addr: 32'h8000_001F, gap: 0, abort_after: 0, fixed: 1'b0, exp_baddr: 32'h8000_0000, exp_done_n: 4};
        vecs[4] = '{addr: 32'h0000_0300, gap: 0, abort_after: 2, fixed: 1'b0, exp_baddr: 32'h0000_0300, exp_done_n: 4};
        vecs[5] = '{addr: 32'h0000_0040, gap: 3, abort_after: 0, fixed: 1'b0, exp_baddr: 32'h0000_0040, exp_done_n: 13};

        rst = 1'b1; pmem_read = 1'b0; pmem_address = '0; burst_rdata = '0; burst_resp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset burst_read", 256'(burst_read), 256'(0));
        checkOutput("reset pmem_resp", 256'(pmem_resp), 256'(0));
        checkOutput("reset pmem_rdata", pmem_rdata, 256'(0));
        checkOutput("reset burst_address", 256'(burst_address), 256'(0));
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].gap, vecs[i].abort_after, vecs[i].fixed,
                          vecs[i].exp_baddr, vecs[i].exp_done_n, 1'b0, 1'b0, 32'h0, $sformatf("vec%0d", i));
            if (i == 0) begin
                checkOutput("vec0 known line", pmem_rdata,
                    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
            end
        end

        applyStimulus(32'h0000_0100, 0, 0, 1'b0, 32'h0000_0100, 4, 1'b0, 1'b1, 32'h0000_0200, "b2b first");
        applyStimulus(32'h0000_0200, 0, 0, 1'b0, 32'h0000_0200, 4, 1'b1, 1'b0, 32'h0, "b2b second");

        pmem_read = 1'b1; pmem_address = 32'h0000_5678;
        @(posedge clk);
        @(negedge clk);
        burst_resp = 1'b1; burst_rdata = {$urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        burst_resp = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("async rst burst_read", 256'(burst_read), 256'(0));
        checkOutput("async rst pmem_resp", 256'(pmem_resp), 256'(0));
        checkOutput("async rst pmem_rdata", pmem_rdata, 256'(0));
        checkOutput("async rst burst_address", 256'(burst_address), 256'(0));
        last_line = '0; model_lines = 0; model_stall = 0;
        pmem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stray_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            burst_resp = 1'b1; burst_rdata = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            if (burst_read || pmem_resp) stray_ok = 1'b0;
        end
        burst_resp = 1'b0;
        checkOutput("stray beats ignored", 256'(stray_ok), 256'(1));
        checkOutput("stray beats rdata", pmem_rdata, 256'(0));
        applyStimulus(32'h0000_5678, 0, 0, 1'b0, 32'h0000_5660, 4, 1'b0, 1'b0, 32'h0, "after reset");

        for (int r = 0; r < 8; r++) begin
            raddr  = $urandom;
            rgap   = int'($urandom_range(0, 3));
            rabort = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            applyStimulus(raddr, rgap, rabort, 1'b0, raddr & ~32'h1F, 3 * rgap + 4,
                          1'b0, 1'b0, 32'h0, $sformatf("rand%0d", r));
        end

`ifdef ICACHE_ADAPTER_PERF_EN
        checkOutput("perf_lines", 256'(perf_lines), 256'(model_lines));
        checkOutput("perf_stall", 256'(perf_stall), 256'(model_stall));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
